// File: rtl/speed_limit_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : speed_sched_pkg
//  Description : Shared types for speed_limit_scheduler. Holds the FSM state
//                enum and the active_src encodings. No ports.
//  Revision    : 1.0 - initial release
// ============================================================================
package speed_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_RAMP_DOWN = 2'd2,
      ST_EMERGENCY = 2'd3
   } state_t;

   localparam logic [1:0] SRC_NONE  = 2'd0;
   localparam logic [1:0] SRC_DRV   = 2'd1;
   localparam logic [1:0] SRC_SIGN  = 2'd2;
   localparam logic [1:0] SRC_EMERG = 2'd3;

endpackage
`default_nettype wire

// File: rtl/speed_limit_scheduler_limit_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : limit_ramp
//  Description : Tick counter plus saturating step of the applied limit
//                toward a target.
//  Ports       : clk, rst (async, active-high)
//                en         - count ticks; low clears the counter
//                up         - step direction (1 = increase)
//                target     - value the step saturates at
//                cur        - current applied limit
//                next       - cur moved one STEP toward target
//                step_pulse - high on the edge where cur should take next
//  Revision    : 1.0 - initial release
// ============================================================================
module limit_ramp #(
   parameter int W           = 8,
   parameter int STEP        = 5,
   parameter int TICK_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up,
   input  logic [W-1:0] target,
   input  logic [W-1:0] cur,
   output logic [W-1:0] next,
   output logic         step_pulse
);

   localparam int          TW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0] C_TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [W:0]   C_STEP_EXT  = (W+1)'(STEP);
   localparam logic [W-1:0] C_STEP      = W'(STEP);

   logic [TW-1:0] r_tick;
   logic [W:0]    w_cur_ext;
   logic [W:0]    w_tgt_ext;
   logic [W:0]    w_up_sum;
   logic [W:0]    w_dn_floor;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick <= '0;
      end else if (!en || r_tick == C_TICK_LAST) begin
         r_tick <= '0;
      end else begin
         r_tick <= r_tick + 1'b1;
      end
   end

   assign step_pulse = en && (r_tick == C_TICK_LAST);

   // One extra bit so cur+STEP near the top of the range cannot wrap
   // before it is compared against the target.
   assign w_cur_ext  = {1'b0, cur};
   assign w_tgt_ext  = {1'b0, target};
   assign w_up_sum   = w_cur_ext + C_STEP_EXT;
   assign w_dn_floor = w_tgt_ext + C_STEP_EXT;

   always_comb begin
      next = target;
      if (up) begin
         if (w_up_sum <= w_tgt_ext) begin
            next = w_up_sum[W-1:0];
         end
      end else begin
         if (w_cur_ext >= w_dn_floor) begin
            next = cur - C_STEP;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/speed_limit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : speed_limit_scheduler
//  Description : Arbitrates driver setpoint, road-sign ceiling and emergency
//                override, then ramps the applied speed limit toward
//                min(driver target, sign ceiling) in fixed steps.
//  Ports       : clk, rst (async, active-high)
//                drv_req/drv_limit   -> drv_ack   driver setpoint handshake
//                sign_req/sign_limit -> sign_ack  road-sign ceiling handshake
//                emerg                            level emergency override
//                speed_limit  applied limit
//                ramping      high while ramping up or down
//                active_src   0 none, 1 driver, 2 sign, 3 emergency
//  Revision    : 1.0 - initial release
// ============================================================================
module speed_limit_scheduler
   import speed_sched_pkg::*;
#(
   parameter int W           = 8,
   parameter int STEP        = 5,
   parameter int TICK_CYCLES = 4,
   parameter int MAX_LIMIT   = 120
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         drv_req,
   input  logic [W-1:0] drv_limit,
   input  logic         sign_req,
   input  logic [W-1:0] sign_limit,
   input  logic         emerg,
   output logic         drv_ack,
   output logic         sign_ack,
   output logic [W-1:0] speed_limit,
   output logic         ramping,
   output logic [1:0]   active_src
);

   localparam logic [W-1:0] C_MAX = W'(MAX_LIMIT);

   state_t       r_state;
   state_t       w_state_next;
   logic [W-1:0] r_speed;
   logic [W-1:0] r_drv_tgt;
   logic [W-1:0] r_sign_ceil;
   logic         r_drv_ack;
   logic         r_sign_ack;

   logic [W-1:0] w_target;
   logic         w_block;
   logic         w_sign_acc;
   logic         w_drv_acc;
   logic         w_ramp_en;
   logic         w_ramp_up;
   logic         w_clear_drv;
   logic [W-1:0] w_next;
   logic         w_step;

   function automatic logic [W-1:0] f_clamp(input logic [W-1:0] v);
      return (v > C_MAX) ? C_MAX : v;
   endfunction

   assign w_target = (r_drv_tgt < r_sign_ceil) ? r_drv_tgt : r_sign_ceil;

   // Acks are also held off on the edge that leaves EMERGENCY: that edge
   // clears the driver target, and a simultaneous accept would be lost.
   assign w_block    = emerg || (r_state == ST_EMERGENCY);
   // A req seen while its own ack is high is the same request, not a new one.
   assign w_sign_acc = !w_block && sign_req && !r_sign_ack;
   assign w_drv_acc  = !w_block && !w_sign_acc && drv_req && !r_drv_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ramp_en    = 1'b0;
      w_ramp_up    = 1'b0;
      w_clear_drv  = 1'b0;
      ramping      = 1'b0;
      active_src   = SRC_NONE;

      if (emerg) begin
         w_state_next = ST_EMERGENCY;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_target > r_speed) begin
                  w_state_next = ST_RAMP_UP;
               end else if (w_target < r_speed) begin
                  w_state_next = ST_RAMP_DOWN;
               end
            end
            ST_RAMP_UP: begin
               if (w_target == r_speed) begin
                  w_state_next = ST_IDLE;
               end else if (w_target < r_speed) begin
                  w_state_next = ST_RAMP_DOWN;
               end else begin
                  w_ramp_en = 1'b1;
                  w_ramp_up = 1'b1;
               end
            end
            ST_RAMP_DOWN: begin
               if (w_target == r_speed) begin
                  w_state_next = ST_IDLE;
               end else if (w_target > r_speed) begin
                  w_state_next = ST_RAMP_UP;
               end else begin
                  w_ramp_en = 1'b1;
               end
            end
            ST_EMERGENCY: begin
               w_state_next = ST_IDLE;
               w_clear_drv  = 1'b1;
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end

      ramping = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN);
      if (r_state == ST_EMERGENCY) begin
         active_src = SRC_EMERG;
      end else if (r_sign_ceil < r_drv_tgt) begin
         active_src = SRC_SIGN;
      end else if (r_drv_tgt != '0) begin
         active_src = SRC_DRV;
      end
   end

   // en drops on entry, direction change and arrival, which restarts the
   // tick count from zero each time.
   limit_ramp #(
      .W           (W),
      .STEP        (STEP),
      .TICK_CYCLES (TICK_CYCLES)
   ) u_ramp (
      .clk        (clk),
      .rst        (rst),
      .en         (w_ramp_en),
      .up         (w_ramp_up),
      .target     (w_target),
      .cur        (r_speed),
      .next       (w_next),
      .step_pulse (w_step)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_speed     <= '0;
         r_drv_tgt   <= '0;
         r_sign_ceil <= C_MAX;
         r_drv_ack   <= 1'b0;
         r_sign_ack  <= 1'b0;
      end else begin
         r_drv_ack  <= w_drv_acc;
         r_sign_ack <= w_sign_acc;

         if (emerg) begin
            r_speed <= '0;
         end else if (w_step) begin
            r_speed <= w_next;
         end

         if (w_clear_drv) begin
            r_drv_tgt <= '0;
         end else if (w_drv_acc) begin
            r_drv_tgt <= f_clamp(drv_limit);
         end

         if (w_sign_acc) begin
            r_sign_ceil <= f_clamp(sign_limit);
         end
      end
   end

   assign drv_ack     = r_drv_ack;
   assign sign_ack    = r_sign_ack;
   assign speed_limit = r_speed;

endmodule
`default_nettype wire
